inv_keyschedule: RTL and testbench

Reverse AES-128 key schedule: a new master key loads the final (round-10) round key and the block walks the schedule backwards, emitting one round key per handshake in the order round 10 down to round 0. It is the decrypt-side counterpart of the forward 15-register key schedule: the decryption datapath consumes round keys in reverse order without storing all eleven. The round-0 output is the original cipher key, so the block also recovers the true key from a final round key.

---
 rtl/inv_keyschedule_if.sv | 22 ++
 rtl/inv_keyschedule.sv | 101 ++++++++++
 tb/tb_inv_keyschedule.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_keyschedule_if.sv
// Handshake bundle for the reverse AES-128 key schedule.
// The producer drives load/last_key/key_ready; the schedule drives the rest.
interface inv_keyschedule_if;
   logic         load;
   logic [127:0] last_key;
   logic         key_ready;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         key_valid;
   logic         busy;
   logic         done;

   modport master (
      output load, last_key, key_ready,
      input  round_key, round_idx, key_valid, busy, done
   );

   modport slave (
      input  load, last_key, key_ready,
      output round_key, round_idx, key_valid, busy, done
   );
endinterface

// File: rtl/inv_keyschedule.sv
// Reverse AES-128 key schedule: walks from the round-10 key back to
// the cipher key, one round key per accepted handshake.
module inv_keyschedule (
   input  logic              eph1,
   input  logic              reset,
   input  logic [255:0][7:0] SBOX,
   inv_keyschedule_if.slave  ks
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t       state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   idx_q, idx_d;
   logic [7:0]   rcon_q, rcon_d;
   logic         valid_q, valid_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   logic [31:0]  n0, n1, n2, n3;
   logic [31:0]  p0, p1, p2, p3;
   logic [31:0]  rot, sub;
   logic [127:0] prev_key;
   logic [7:0]   rcon_nxt;

   // Undo one expansion step: recover the previous key's words
   assign {n0, n1, n2, n3} = key_q;
   assign p3  = n3 ^ n2;
   assign p2  = n2 ^ n1;
   assign p1  = n1 ^ n0;
   assign rot = {p3[23:0], p3[31:24]};
   assign sub = {SBOX[rot[31:24]], SBOX[rot[23:16]],
                 SBOX[rot[15:8]],  SBOX[rot[7:0]]};
   assign p0  = n0 ^ sub ^ {rcon_q, 24'h0};
   assign prev_key = {p0, p1, p2, p3};

   assign rcon_nxt = (rcon_q == 8'h1b) ? 8'h80 : (rcon_q >> 1);

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      idx_d   = idx_q;
      rcon_d  = rcon_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ks.load) begin
               state_d = RUN;
               key_d   = ks.last_key;
               idx_d   = 4'd10;
               rcon_d  = 8'h36;
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            if (ks.key_ready) begin
               if (idx_q != 4'd0) begin
                  key_d  = prev_key;
                  idx_d  = idx_q - 4'd1;
                  rcon_d = rcon_nxt;
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge eph1 or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         key_q   <= '0;
         idx_q   <= '0;
         rcon_q  <= 8'h36;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         idx_q   <= idx_d;
         rcon_q  <= rcon_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign ks.round_key = key_q;
   assign ks.round_idx = idx_q;
   assign ks.key_valid = valid_q;
   assign ks.busy      = busy_q;
   assign ks.done      = done_q;

endmodule

// File: tb/tb_inv_keyschedule.sv
// Bench for inv_keyschedule: forward AES-128 expansion model built from
// a GF(2^8) S-box, compared against the reverse walk.
module tb_inv_keyschedule;

   localparam logic [127:0] A1_CK   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] A1_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   logic              eph1;
   logic              reset;
   logic [255:0][7:0] sbox;
   logic [127:0]      exp_rk [0:10];
   int                tests;
   int                fails;

   inv_keyschedule_if ks();

   inv_keyschedule dut (
      .eph1  (eph1),
      .reset (reset),
      .SBOX  (sbox),
      .ks    (ks)
   );

   initial eph1 = 1'b0;
   always #5 eph1 = ~eph1;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_of(input logic [7:0] x);
      logic [7:0] v;
      v = 8'h00;
      for (int y = 1; y < 256; y++)
         if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
               ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   // Forward FIPS-197 expansion of a cipher key into exp_rk[0..10]
   task automatic expand(input logic [127:0] ck);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++)
         exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge eph1);
      tests++;
      if ({ks.key_valid, ks.busy, ks.done, ks.round_idx, ks.round_key} !== '0) begin
         fails++;
         $display("FAIL reset_state: got v%b b%b d%b idx%0d key=%h, want all zero",
                  ks.key_valid, ks.busy, ks.done, ks.round_idx, ks.round_key);
      end
      reset = 1'b0;
      @(negedge eph1);
      tests++;
      if ({ks.key_valid, ks.busy, ks.done} !== 3'b000) begin
         fails++;
         $display("FAIL idle_after_reset: got v%b b%b d%b, want 000",
                  ks.key_valid, ks.busy, ks.done);
      end
   endtask

   task automatic test_fips;
      logic [131:0] want;
      ks.key_ready = 1'b1;
      @(negedge eph1);
      ks.load = 1'b1;
      ks.last_key = A1_LAST;
      @(negedge eph1);
      ks.load = 1'b0;
      for (int i = 10; i >= 0; i--) begin
         want = '0;
         case (i)
            10: want = {4'd10, A1_LAST};
            9:  want = {4'd9,  128'hac7766f319fadc2128d12941575c006e};
            1:  want = {4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
            0:  want = {4'd0,  A1_CK};
            default: want = '0;
         endcase
         if (i == 10 || i == 9 || i == 1 || i == 0) begin
            tests++;
            if ({ks.round_idx, ks.round_key} !== want) begin
               fails++;
               $display("FAIL fips_round%0d: got idx%0d %h, want idx%0d %h",
                        i, ks.round_idx, ks.round_key, want[131:128], want[127:0]);
            end
         end
         @(negedge eph1);
      end
      tests++;
      if (ks.done !== 1'b1) begin
         fails++;
         $display("FAIL fips_done: got %b want 1", ks.done);
      end
      ks.key_ready = 1'b0;
      @(negedge eph1);
   endtask

   // Generic walk: cipher key ck, key_ready probability pct (percent),
   // optional load pulse mid-walk and optional reload in the done cycle.
   task automatic test_walk(input string name, input logic [127:0] ck,
                            input int pct, input bit ld_run, input bit ld_done);
      logic [134:0] got;
      logic [134:0] want;
      int  r;
      int  n;
      bit  fin;
      bit  rdy;
      int  passes;
      expand(ck);
      passes = ld_done ? 2 : 1;
      ks.key_ready = 1'b0;
      @(negedge eph1);
      ks.load = 1'b1;
      ks.last_key = exp_rk[10];
      @(negedge eph1);
      ks.load = 1'b0;
      ks.last_key = {$urandom, $urandom, $urandom, $urandom};
      for (int pass = 0; pass < passes; pass++) begin
         r = 10;
         n = 0;
         fin = 1'b0;
         while (!fin && n < 500) begin
            n++;
            got  = {ks.key_valid, ks.busy, ks.done, ks.round_idx, ks.round_key};
            want = {3'b110, 4'(r), exp_rk[r]};
            tests++;
            if (got !== want) begin
               fails++;
               $display("FAIL %s step: got %h, want %h", name, got, want);
            end
            if (ld_run && n == 3) begin
               ks.load = 1'b1;
               ks.last_key = {$urandom, $urandom, $urandom, $urandom};
            end
            rdy = (pct >= 100) || ($urandom_range(0, 99) < pct);
            ks.key_ready = rdy;
            @(negedge eph1);
            ks.load = 1'b0;
            if (rdy) begin
               if (r == 0) fin = 1'b1;
               else r--;
            end
         end
         if (!fin) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: walk stuck at round %0d", name, r);
         end
         got  = {ks.key_valid, ks.busy, ks.done, ks.round_idx, ks.round_key};
         want = {3'b001, 4'd0, exp_rk[0]};
         tests++;
         if (got !== want) begin
            fails++;
            $display("FAIL %s done_cycle: got %h, want %h", name, got, want);
         end
         ks.key_ready = 1'b0;
         if (pass == 0 && ld_done) begin
            ks.load = 1'b1;
            ks.last_key = exp_rk[10];
         end
         @(negedge eph1);
         ks.load = 1'b0;
         if (pass == passes - 1) begin
            tests++;
            if ({ks.key_valid, ks.busy, ks.done} !== 3'b000) begin
               fails++;
               $display("FAIL %s idle_after: got v%b b%b d%b, want 000",
                        name, ks.key_valid, ks.busy, ks.done);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      ks.key_ready = 1'b1;
      @(negedge eph1);
      ks.load = 1'b1;
      ks.last_key = A1_LAST;
      @(negedge eph1);
      ks.load = 1'b0;
      repeat (5) @(negedge eph1);
      tests++;
      if (ks.round_idx !== 4'd5) begin
         fails++;
         $display("FAIL mid_idx: got %0d want 5", ks.round_idx);
      end
      reset = 1'b1;
      #1;
      tests++;
      if ({ks.key_valid, ks.busy, ks.done, ks.round_idx, ks.round_key} !== '0) begin
         fails++;
         $display("FAIL mid_reset_async: got v%b b%b idx%0d key=%h, want zero",
                  ks.key_valid, ks.busy, ks.round_idx, ks.round_key);
      end
      @(negedge eph1);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge eph1);
         tests++;
         if ({ks.key_valid, ks.busy, ks.done} !== 3'b000) begin
            fails++;
            $display("FAIL post_reset_idle: got v%b b%b d%b, want 000",
                     ks.key_valid, ks.busy, ks.done);
         end
      end
      ks.key_ready = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      ks.load = 1'b0;
      ks.key_ready = 1'b0;
      ks.last_key = '0;
      for (int i = 0; i < 256; i++) sbox[i] = sbox_of(8'(i));
      test_reset();
      test_fips();
      test_walk("a1_model", A1_CK, 100, 1'b0, 1'b0);
      test_walk("zero_key", 128'h0, 100, 1'b0, 1'b0);
      test_walk("backpressure", A1_CK, 50, 1'b0, 1'b0);
      test_walk("load_in_run", A1_CK, 100, 1'b1, 1'b0);
      test_walk("load_in_done", A1_CK, 70, 1'b0, 1'b1);
      test_reset_mid();
      test_walk("after_reset", A1_CK, 100, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++)
         test_walk("cross_check", {$urandom, $urandom, $urandom, $urandom},
                   (k % 2 == 0) ? 100 : 40, 1'b0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
